// File: rtl/hidden_input_mac.sv
// Hidden-layer MAC: sequences MFCC/weight fetches per neuron, accumulates Q-format products
// and emits one saturated sum per neuron. Define HIDDEN_MAC_RELU_EN to clamp negative sums to zero.
module hidden_input_mac #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int ACC_WIDTH   = 64,
    parameter int N_INPUTS    = 128,
    parameter int N_NEURONS   = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ena_hidden_input_mac,
    output logic [5:0]            in_weight_case,
    input  logic [DATA_WIDTH-1:0] mac_mfcc,
    input  logic [DATA_WIDTH-1:0] mac_weight,
    output logic [DATA_WIDTH-1:0] neuron_data,
    output logic [5:0]            neuron_idx,
    output logic                  neuron_valid,
    input  logic                  neuron_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W     = $clog2(N_INPUTS) + 1;
    localparam int DRAIN_CYC = MEM_LATENCY + 2;
    localparam int DRN_W     = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              case_q, case_d;
    logic [CNT_W-1:0]        issueCnt_q, issueCnt_d;
    logic [DRN_W-1:0]        drainCnt_q, drainCnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [5:0]              idx_q, idx_d;
    logic                    accClr;

    logic [MEM_LATENCY-1:0]        vld_q;
    logic                          captureValid;
    logic signed [2*DATA_WIDTH-1:0] prodFull, prod_q, prodShr;
    logic                          prodVld_q;
    logic signed [ACC_WIDTH-1:0]   acc_q, termExt;
    logic [ACC_WIDTH-DATA_WIDTH:0] accTop;
    logic [DATA_WIDTH-1:0]         satData;

    assign ena_hidden_input_mac = (state_q == S_ISSUE);
    assign in_weight_case       = case_q;
    assign neuron_data          = data_q;
    assign neuron_idx           = idx_q;
    assign neuron_valid         = (state_q == S_EMIT);
    assign busy                 = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_EMIT);
    assign done                 = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            case_q     <= '0;
            issueCnt_q <= '0;
            drainCnt_q <= '0;
            data_q     <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            case_q     <= case_d;
            issueCnt_q <= issueCnt_d;
            drainCnt_q <= drainCnt_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
        end
    end

    // DRAIN waits out the fetch latency plus the product and accumulate stages
    always_comb begin
        state_d    = state_q;
        case_d     = case_q;
        issueCnt_d = issueCnt_q;
        drainCnt_d = drainCnt_q;
        data_d     = data_q;
        idx_d      = idx_q;
        accClr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    case_d     = '0;
                    issueCnt_d = '0;
                    accClr     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issueCnt_q == CNT_W'(N_INPUTS - 1)) begin
                    state_d    = S_DRAIN;
                    drainCnt_d = '0;
                end else begin
                    issueCnt_d = issueCnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drainCnt_q == DRN_W'(DRAIN_CYC - 1)) begin
                    state_d = S_EMIT;
                    data_d  = satData;
                    idx_d   = case_q;
                end else begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (neuron_ready) begin
                    accClr = 1'b1;
                    if (case_q == 6'(N_NEURONS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ISSUE;
                        case_d     = case_q + 1'b1;
                        issueCnt_d = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                case_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign captureValid = vld_q[MEM_LATENCY-1];
    assign prodFull     = (2*DATA_WIDTH)'($signed(mac_mfcc)) * (2*DATA_WIDTH)'($signed(mac_weight));
    assign prodShr      = prod_q >>> FRAC_BITS;
    assign termExt      = ACC_WIDTH'(prodShr);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            prod_q    <= '0;
            prodVld_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            vld_q[0] <= ena_hidden_input_mac;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (captureValid) begin
                prod_q <= prodFull;
            end
            prodVld_q <= captureValid;
            if (accClr) begin
                acc_q <= '0;
            end else if (prodVld_q) begin
                acc_q <= acc_q + termExt;
            end
        end
    end

    // The sum fits when every accumulator bit above the output sign bit matches it
    assign accTop = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];

    always_comb begin
        satData = acc_q[DATA_WIDTH-1:0];
        if (!((&accTop) || (~|accTop))) begin
            if (acc_q[ACC_WIDTH-1]) begin
                satData = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                satData = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
`ifdef HIDDEN_MAC_RELU_EN
        if (satData[DATA_WIDTH-1]) begin
            satData = '0;
        end
`else
        satData = satData;
`endif
    end

endmodule
